// File: rtl/asg_pkg.sv
// Shared constants and sizing helper for the alternating step generator
// and its downstream stages.
package asg_pkg;

  localparam int ASG_WORD_WIDTH = 8;
  localparam int ASG_REP_LIMIT  = 32;

  // Bits needed for a counter that must hold every value 0..max_val.
  function automatic int asg_cnt_width(input int max_val);
    if (max_val < 2) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/asg_byte_packer_if.sv
// Word stream from the byte packer to its consumer (valid/ready handshake).
interface asg_byte_packer_if
  import asg_pkg::*;
#(
  parameter int WIDTH = ASG_WORD_WIDTH
);

  logic [WIDTH-1:0] word_data;
  logic             word_valid;
  logic             word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/asg_rep_monitor.sv
// Repetition-count health test on the consumed keystream bits; raises a
// sticky flag after REP_LIMIT identical consecutive bits.
module asg_rep_monitor
  import asg_pkg::*;
#(
  parameter int REP_LIMIT = ASG_REP_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic consume,
  input  logic bit_in,
  input  logic clear,
  output logic stuck
);

  localparam int            RW      = asg_cnt_width(REP_LIMIT);
  localparam logic [RW-1:0] REP_MAX = RW'(REP_LIMIT);
  localparam logic [RW-1:0] REP_ONE = RW'(1);

  logic [RW-1:0] rep_r;
  logic [RW-1:0] rep_inc_s;
  logic [RW-1:0] rep_nxt_s;
  logic          last_r;
  logic          last_nxt_s;
  logic          stuck_r;
  logic          stuck_nxt_s;
  logic          trip_s;

  // Next-state: saturating run length, trip detection, clear (trip wins for stuck).
  always_comb begin
    rep_inc_s   = rep_r;
    rep_nxt_s   = rep_r;
    last_nxt_s  = last_r;
    trip_s      = 1'b0;
    stuck_nxt_s = stuck_r;

    if (bit_in == last_r) begin
      if (rep_r < REP_MAX) begin
        rep_inc_s = rep_r + REP_ONE;
      end else begin
        rep_inc_s = REP_MAX;
      end
    end else begin
      rep_inc_s = REP_ONE;
    end

    if (consume) begin
      trip_s     = (rep_inc_s == REP_MAX);
      last_nxt_s = bit_in;
      rep_nxt_s  = clear ? {RW{1'b0}} : rep_inc_s;
    end else begin
      trip_s     = 1'b0;
      last_nxt_s = last_r;
      rep_nxt_s  = clear ? {RW{1'b0}} : rep_r;
    end

    stuck_nxt_s = trip_s | (stuck_r & ~clear);
  end

  // Health-test state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_r   <= {RW{1'b0}};
      last_r  <= 1'b0;
      stuck_r <= 1'b0;
    end else begin
      rep_r   <= rep_nxt_s;
      last_r  <= last_nxt_s;
      stuck_r <= stuck_nxt_s;
    end
  end

  assign stuck = stuck_r;

endmodule

// File: rtl/asg_byte_packer.sv
// Consumes ASG keystream bits, packs them MSB-first into WIDTH-bit words on
// a valid/ready stream, and back-pressures the generator when the slot is full.
module asg_byte_packer
  import asg_pkg::*;
#(
  parameter int WIDTH     = ASG_WORD_WIDTH,
  parameter int REP_LIMIT = ASG_REP_LIMIT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic                      asg_bit,
  output logic                      asg_enable,
  asg_byte_packer_if.master         word_if,
  input  logic                      clear_stuck,
  output logic                      stuck
);

  localparam int            CW       = asg_cnt_width(WIDTH - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-2:0] sh_r;
  logic [WIDTH-2:0] sh_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] data_nxt_s;
  logic             valid_r;
  logic             valid_nxt_s;
  logic [WIDTH-1:0] shifted_s;
  logic             stall_s;
  logic             consume_s;
  logic             complete_s;

  // Stall/consume decision and next state of the packer.
  always_comb begin
    shifted_s   = {sh_r, asg_bit};
    stall_s     = (cnt_r == CNT_LAST) && valid_r && !word_if.word_ready;
    consume_s   = rst_n && run && !stall_s;
    complete_s  = consume_s && (cnt_r == CNT_LAST);
    sh_nxt_s    = sh_r;
    cnt_nxt_s   = cnt_r;
    data_nxt_s  = data_r;
    valid_nxt_s = valid_r;

    // Completing a word may overwrite the slot: stall guarantees it is empty or draining.
    if (complete_s) begin
      data_nxt_s  = shifted_s;
      valid_nxt_s = 1'b1;
      cnt_nxt_s   = {CW{1'b0}};
    end else if (consume_s) begin
      sh_nxt_s    = shifted_s[WIDTH-2:0];
      cnt_nxt_s   = cnt_r + CNT_ONE;
      valid_nxt_s = valid_r && !word_if.word_ready;
    end else begin
      valid_nxt_s = valid_r && !word_if.word_ready;
    end
  end

  // Packer state and registered output slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_r    <= {(WIDTH-1){1'b0}};
      cnt_r   <= {CW{1'b0}};
      data_r  <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
    end else begin
      sh_r    <= sh_nxt_s;
      cnt_r   <= cnt_nxt_s;
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  asg_rep_monitor #(
    .REP_LIMIT (REP_LIMIT)
  ) u_rep_monitor (
    .clk     (clk),
    .rst_n   (rst_n),
    .consume (consume_s),
    .bit_in  (asg_bit),
    .clear   (clear_stuck),
    .stuck   (stuck)
  );

  assign asg_enable         = consume_s;
  assign word_if.word_data  = data_r;
  assign word_if.word_valid = valid_r;

endmodule

// File: tb/tb_asg_byte_packer.sv
// Self-checking bench for asg_byte_packer: directed table, hand sequences for
// stall/gap/health/reset, and a randomized run against a bit-stream model.
module tb_asg_byte_packer;

  localparam int WIDTH     = 8;
  localparam int REP_LIMIT = 32;

  logic clk;
  logic rst_n;
  logic run;
  logic asg_bit;
  logic asg_enable;
  logic clear_stuck;
  logic stuck;

  asg_byte_packer_if #(.WIDTH(WIDTH)) wif ();

  asg_byte_packer #(
    .WIDTH     (WIDTH),
    .REP_LIMIT (REP_LIMIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .asg_bit     (asg_bit),
    .asg_enable  (asg_enable),
    .word_if     (wif),
    .clear_stuck (clear_stuck),
    .stuck       (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: consumed bits of the word being built, finished words
  // not yet taken by the consumer, and the run-length health test.
  bit               cur_bits[$];
  logic [WIDTH-1:0] wordq[$];
  int               rep_m;
  bit               last_m;
  bit               stuck_m;

  typedef struct {
    logic       run;
    logic       bit_v;
    logic       ready;
    logic       clr;
    logic       exp_en;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_stuck;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    cur_bits.delete();
    wordq.delete();
    rep_m   = 0;
    last_m  = 1'b0;
    stuck_m = 1'b0;
  endfunction

  function automatic void model_edge(input bit en, input bit b, input bit rdy, input bit clr);
    int nrep;
    int wv;
    bit trip;
    trip = 1'b0;
    if (wordq.size() != 0 && rdy) void'(wordq.pop_front());
    if (en) begin
      cur_bits.push_back(b);
      if (cur_bits.size() == WIDTH) begin
        wv = 0;
        foreach (cur_bits[i]) wv = wv * 2 + int'(cur_bits[i]);
        wordq.push_back(WIDTH'(wv));
        cur_bits.delete();
      end
      if (b == last_m) nrep = (rep_m < REP_LIMIT) ? rep_m + 1 : REP_LIMIT;
      else nrep = 1;
      trip   = (nrep == REP_LIMIT);
      last_m = b;
      rep_m  = nrep;
    end
    if (clr) rep_m = 0;
    stuck_m = trip || (stuck_m && !clr);
  endfunction

  // One clock cycle: drive, check enable, clock, check registered outputs.
  task automatic drive_cycle(input logic r, input logic b, input logic rdy, input logic clr,
                             output logic en_obs);
    logic exp_en;
    run            = r;
    asg_bit        = b;
    wif.word_ready = rdy;
    clear_stuck    = clr;
    #1;
    exp_en = r && !((cur_bits.size() == WIDTH - 1) && (wordq.size() != 0) && !rdy);
    en_obs = asg_enable;
    check("model_enable", 32'(asg_enable), 32'(exp_en));
    @(posedge clk);
    model_edge(exp_en, b, rdy, clr);
    #1;
    check("model_valid", 32'(wif.word_valid), 32'(wordq.size() != 0));
    if (wordq.size() != 0) check("model_data", 32'(wif.word_data), 32'(wordq[0]));
    check("model_stuck", 32'(stuck), 32'(stuck_m));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_enable", 32'(asg_enable), 32'd0);
    check("rst_valid", 32'(wif.word_valid), 32'd0);
    check("rst_data", 32'(wif.word_data), 32'd0);
    check("rst_stuck", 32'(stuck), 32'd0);
    run            = 1'b0;
    asg_bit        = 1'b0;
    wif.word_ready = 1'b0;
    clear_stuck    = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    logic        en;
    logic [15:0] pat;
    logic        bv[32];
    int          wv;
    logic        rb;

    rst_n          = 1'b1;
    run            = 1'b0;
    asg_bit        = 1'b0;
    wif.word_ready = 1'b0;
    clear_stuck    = 1'b0;
    model_reset();
    #2;

    // Directed table: two back-to-back words, 8'hB2 then 8'h5C.
    pat = 16'b1011_0010_0101_1100;
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{run: 1'b1, bit_v: pat[15-i], ready: 1'b1, clr: 1'b0, exp_en: 1'b1,
                 exp_valid: (i == 7 || i == 15), exp_data: (i <= 7) ? 8'hB2 : 8'h5C,
                 exp_stuck: 1'b0};
    end
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      drive_cycle(tbl[i].run, tbl[i].bit_v, tbl[i].ready, tbl[i].clr, en);
      check("tbl_enable", 32'(en), 32'(tbl[i].exp_en));
      check("tbl_valid", 32'(wif.word_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) check("tbl_data", 32'(wif.word_data), 32'(tbl[i].exp_data));
      check("tbl_stuck", 32'(stuck), 32'(tbl[i].exp_stuck));
    end

    // Consumer stalled from cycle 0, released in cycle 20.
    apply_reset();
    for (int i = 0; i < 32; i++) bv[i] = 1'($urandom_range(0, 1));
    for (int c = 0; c < 20; c++) begin
      drive_cycle(1'b1, bv[c], 1'b0, 1'b0, en);
      check("stall_enable", 32'(en), 32'(c < 15));
      if (c == 7) check("stall_first_valid", 32'(wif.word_valid), 32'd1);
    end
    drive_cycle(1'b1, bv[20], 1'b1, 1'b0, en);
    check("resume_enable", 32'(en), 32'd1);
    check("resume_valid", 32'(wif.word_valid), 32'd1);
    wv = 0;
    for (int i = 8; i < 15; i++) wv = wv * 2 + int'(bv[i]);
    wv = wv * 2 + int'(bv[20]);
    check("resume_word", 32'(wif.word_data), 32'(wv));
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, en);

    // run gap of 5 cycles after 3 bits.
    apply_reset();
    for (int i = 0; i < 32; i++) bv[i] = 1'($urandom_range(0, 1));
    for (int c = 0; c < 13; c++) begin
      drive_cycle((c < 3 || c >= 8), bv[c], 1'b1, 1'b0, en);
      if (c >= 3 && c < 8) check("gap_enable", 32'(en), 32'd0);
    end
    wv = 0;
    for (int i = 0; i < 3; i++) wv = wv * 2 + int'(bv[i]);
    for (int i = 8; i < 13; i++) wv = wv * 2 + int'(bv[i]);
    check("gap_valid", 32'(wif.word_valid), 32'd1);
    check("gap_word", 32'(wif.word_data), 32'(wv));

    // Health test on a constant-zero stream.
    apply_reset();
    for (int k = 1; k <= 32; k++) begin
      drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, en);
      if (k == 31) check("stuck_31", 32'(stuck), 32'd0);
      if (k == 32) check("stuck_32", 32'(stuck), 32'd1);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, en);
    check("stuck_cleared", 32'(stuck), 32'd0);
    for (int k = 1; k <= 32; k++) begin
      drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, en);
      if (k == 31) check("stuck_again_31", 32'(stuck), 32'd0);
      if (k == 32) check("stuck_again_32", 32'(stuck), 32'd1);
    end
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, en);
    check("stuck_cleared2", 32'(stuck), 32'd0);
    for (int k = 1; k <= 31; k++) drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, en);
    check("stuck_pre_trip", 32'(stuck), 32'd0);
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, en);
    check("stuck_clear_vs_trip", 32'(stuck), 32'd1);

    // Reset mid-word with a pending output word.
    apply_reset();
    for (int c = 0; c < 13; c++) drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, en);
    check("pre_reset_valid", 32'(wif.word_valid), 32'd1);
    run = 1'b1;
    apply_reset();
    for (int i = 0; i < 8; i++) bv[i] = 1'($urandom_range(0, 1));
    for (int c = 0; c < 8; c++) drive_cycle(1'b1, bv[c], 1'b1, 1'b0, en);
    wv = 0;
    for (int i = 0; i < 8; i++) wv = wv * 2 + int'(bv[i]);
    check("post_reset_valid", 32'(wif.word_valid), 32'd1);
    check("post_reset_word", 32'(wif.word_data), 32'(wv));

    // Randomized run/ready/bits against the model.
    apply_reset();
    rb = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (c < 5000) begin
        if ($urandom_range(0, 15) == 0) rb = ~rb;
      end else begin
        rb = 1'($urandom_range(0, 1));
      end
      drive_cycle(($urandom_range(0, 9) < 8), rb, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 199) == 0), en);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
